// File: rtl/gcd_binary_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes on operands and result.
// Optional CALC-cycle counter port `cycles` when GCD_CYCLE_COUNT_EN is defined.
module gcd_binary_engine #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a_in,
  input  logic [NBITS-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] result
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam int unsigned KW = $clog2(NBITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (NBITS < 2 || CNT_W < 1) begin : g_param_chk
    $error("gcd_binary_engine: NBITS must be >= 2 and CNT_W >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
      cyc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef GCD_CYCLE_COUNT_EN
      cyc_q       <= cyc_d;
`endif
    end
  end

  // Next-state logic; one Stein reduction step per CALC cycle
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef GCD_CYCLE_COUNT_EN
    cyc_d       = cyc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a_in;
          b_d        = b_in;
          k_d        = '0;
          in_ready_d = 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
          cyc_d      = '0;
`endif
          if (a_in == '0 || b_in == '0) begin
            // With one operand zero the OR is the other operand (or zero)
            result_d    = a_in | b_in;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
        if (cyc_q != {CNT_W{1'b1}}) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
`endif
        if (a_q == b_q) begin
          result_d    = a_q << k_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef GCD_CYCLE_COUNT_EN
  assign cycles    = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_binary_engine.sv
// Directed and randomized self-checking bench for gcd_binary_engine (NBITS=32).
module tb_gcd_binary_engine;

  localparam int unsigned NBITS = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] a_in;
  logic [NBITS-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] result;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles;
`endif

  int checks;
  int failures;

  gcd_binary_engine #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Euclid by remainder, independent of the hardware's shift/subtract method
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, then wait for out_valid; lat counts edges from the accepting edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit rnd_rdy,
                        output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_op", in_ready, 1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check("out_valid_arrives", out_valid, 1);
    check("in_ready_low_in_done", in_ready, 0);
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_accept", out_valid, 0);
    check("in_ready_after_accept", in_ready, 1);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] a, b;
    int          lat;
    int          results;

    checks    = 0;
    failures  = 0;
    results   = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;

    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
`ifdef GCD_CYCLE_COUNT_EN
    check("rst_cycles", cycles, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Basic Stein run with one shared factor of two
    run_op(32'd48, 32'd18, 1'b0, res, lat);
    check("gcd_48_18", res, 6);
    check("lat_48_18", lat, 7);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_48_18", cycles, 6);
`endif
    consume();

    // Zero-operand shortcut
    run_op(32'd0, 32'd7, 1'b0, res, lat);
    check("gcd_0_7", res, 7);
    check("lat_0_7", lat, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_0_7", cycles, 0);
`endif
    consume();
    run_op(32'd9, 32'd0, 1'b0, res, lat);
    check("gcd_9_0", res, 9);
    check("lat_9_0", lat, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_9_0", cycles, 0);
`endif
    consume();
    run_op(32'd0, 32'd0, 1'b0, res, lat);
    check("gcd_0_0", res, 0);
    check("lat_0_0", lat, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_0_0", cycles, 0);
`endif
    consume();

    // Equal operands, pure powers of two, coprime odds
    run_op(32'd255, 32'd255, 1'b0, res, lat);
    check("gcd_255_255", res, 255);
    check("lat_255_255", lat, 2);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_255_255", cycles, 1);
`endif
    consume();
    run_op(32'd128, 32'd64, 1'b0, res, lat);
    check("gcd_128_64", res, 64);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_128_64", cycles, 8);
`endif
    consume();
    run_op(32'd17, 32'd13, 1'b0, res, lat);
    check("gcd_17_13", res, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cyc_17_13", cycles, 6);
`endif
    consume();

    // Back-pressure: result held, new operands ignored while DONE
    run_op(32'd48, 32'd18, 1'b0, res, lat);
    a_in     = 32'd5;
    b_in     = 32'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 6);
      check("bp_in_ready", in_ready, 0);
`ifdef GCD_CYCLE_COUNT_EN
      check("bp_cycles", cycles, 6);
`endif
    end
    in_valid = 1'b0;
    consume();
    tick();
    check("bp_no_extra_result", out_valid, 0);

    // Asynchronous reset two cycles into CALC
    a_in     = 32'd1000;
    b_in     = 32'd24;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midcalc_busy", in_ready, 0);
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("abort_no_output", out_valid, 0);
    run_op(32'd1000, 32'd24, 1'b0, res, lat);
    check("gcd_1000_24", res, 8);
    consume();

    // Randomized sweep with gaps on both handshakes
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'h0000_0FFF) << $urandom_range(0, 4);
      b = ($urandom & 32'h0000_0FFF) << $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      repeat ($urandom_range(0, 3)) tick();
      run_op(a, b, 1'b1, res, lat);
      results++;
      check("rnd_gcd", res, ref_gcd(a, b));
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("rnd_hold", result, res);
      end
      consume();
    end
    tick();
    check("rnd_result_count", results, 300);
    check("rnd_idle_at_end", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
